// File: rtl/cfg_chain_loader_pkg.sv
// Shared definitions for the configuration chain loader.
//   ERR_* : sticky error codes reported on the err output
//   state_e : loader FSM states
//   words_needed() : buffered words required before a command is accepted
package cfg_chain_loader_pkg;

  localparam int unsigned ID_WIDTH_DEFAULT = 8;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_UNDERRUN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ID,
    ST_PAYLOAD,
    ST_WAIT_ECHO
  } state_e;

  // min(2, ceil(len / word_w)): a frame only starts once its first two
  // words (or all of them, if fewer) are already buffered.
  function automatic logic [1:0] words_needed(input logic [31:0] len,
                                              input int unsigned word_w);
    if (len == '0)          return 2'd0;
    else if (len <= word_w) return 2'd1;
    else                    return 2'd2;
  endfunction

endpackage

// File: rtl/cfg_word_fifo.sv
// Two-entry payload word buffer.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   push_i, wdata_i    : write a word (accepted when not full, or full with pop)
//   pop_i, rdata_o     : drop the head word; rdata_o shows the head
//   full_o, empty_o    : occupancy flags
//   count_o            : words held (0..2)
module cfg_word_fifo #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [1:0]        count_o
);

  logic [WORD_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // On a full buffer a simultaneous pop frees the slot the write targets.
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/cfg_chain_loader.sv
// Configuration daisy-chain master.
//   clk, crst                      : clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_id/cmd_len : frame command (tile id, payload bits)
//   data_valid/data_ready/data_word    : payload words, sent LSB first
//   cfg_in_start, cfg_bit_in       : serial frame to the chain head
//   cfg_out_start, cfg_bit_out     : start marker / data from the chain tail
//   busy, done, err                : status (err sticky until next accept)
module cfg_chain_loader
  import cfg_chain_loader_pkg::*;
#(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned ID_WIDTH = ID_WIDTH_DEFAULT,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic                clk,
  input  logic                crst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ID_WIDTH-1:0] cmd_id,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic [WORD_W-1:0]   data_word,
  output logic                cfg_in_start,
  output logic                cfg_bit_in,
  input  logic                cfg_out_start,
  input  logic                cfg_bit_out,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err
);

  localparam int unsigned BIDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned IDC_W  = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT);

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [IDC_W-1:0]    idc_q, idc_d;
  logic [TO_W-1:0]     wcnt_q, wcnt_d;
  logic [1:0]          err_q, err_d;
  logic                done_q, done_d;

  logic [WORD_W-1:0]   fifo_rdata;
  logic [1:0]          fifo_count;
  logic                fifo_full;
  logic                unused_fifo_empty;
  logic                unused_tail_bit;
  logic                push, pop, cmd_fire;
  logic                last_word_bit, last_frame_bit, starved;

  assign unused_tail_bit = cfg_bit_out;

  assign data_ready = !crst && !fifo_full;
  assign push       = data_valid && data_ready;
  assign cmd_ready  = !crst && (state_q == ST_IDLE) &&
                      (fifo_count >= words_needed(32'(cmd_len), WORD_W));
  assign cmd_fire   = cmd_valid && cmd_ready;

  assign last_word_bit  = (bidx_q == BIDX_W'(WORD_W - 1));
  assign last_frame_bit = (rem_q == LEN_W'(1));
  assign pop            = (state_q == ST_PAYLOAD) && (last_word_bit || last_frame_bit);
  // The word after a mid-frame pop must already be buffered for the next
  // cycle; a push landing in the same cycle as the pop still counts.
  assign starved        = pop && !last_frame_bit && (fifo_count == 2'd1) && !push;

  cfg_word_fifo #(.WORD_W(WORD_W)) u_fifo (
    .clk_i   (clk),
    .rst_i   (crst),
    .push_i  (push),
    .wdata_i (data_word),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (unused_fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (crst) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      rem_q   <= '0;
      bidx_q  <= '0;
      idc_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= ERR_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      rem_q   <= rem_d;
      bidx_q  <= bidx_d;
      idc_q   <= idc_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    rem_d        = rem_q;
    bidx_d       = bidx_q;
    idc_d        = idc_q;
    wcnt_d       = wcnt_q;
    err_d        = err_q;
    done_d       = 1'b0;
    cfg_in_start = 1'b0;
    cfg_bit_in   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          id_d    = cmd_id;
          rem_d   = cmd_len;
          bidx_d  = '0;
          idc_d   = '0;
          err_d   = ERR_NONE;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cfg_in_start = 1'b1;
        state_d      = ST_ID;
      end
      ST_ID: begin
        // id_q shifts left so its MSB is always the bit on the wire.
        cfg_bit_in = id_q[ID_WIDTH-1];
        id_d       = id_q << 1;
        idc_d      = idc_q + 1'b1;
        if (idc_q == IDC_W'(ID_WIDTH - 1)) begin
          idc_d   = '0;
          wcnt_d  = '0;
          state_d = (rem_q == '0) ? ST_WAIT_ECHO : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        // rem_q counts down remaining bits, so a full-range len never wraps.
        cfg_bit_in = fifo_rdata[bidx_q];
        rem_d      = rem_q - 1'b1;
        bidx_d     = last_word_bit ? '0 : bidx_q + 1'b1;
        if (last_frame_bit) begin
          bidx_d  = '0;
          wcnt_d  = '0;
          state_d = ST_WAIT_ECHO;
        end else if (starved) begin
          bidx_d  = '0;
          err_d   = ERR_UNDERRUN;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_ECHO: begin
        if (cfg_out_start) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (wcnt_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: doc/cfg_chain_loader.md
Name: cfg_chain_loader

Overview:
- Master for the tile configuration daisy chain.
- Takes frame commands (target tile ID + payload length) and payload words from the host side.
- Serializes each frame onto the chain head via cfg_in_start/cfg_bit_in, one bit per clk.
- Confirms delivery by watching the start marker return at the chain tail; reports done, underrun or timeout per frame.

Parameters:
- WORD_W, 32, payload word width from host.
- ID_WIDTH, 8, tile ID field width; must equal the tiles' ID_WIDTH.
- LEN_W, 16, width of payload bit-count field.
- TIMEOUT, 4096, max cycles in WAIT_ECHO before error; ≥ 2.

Ports:
- clk  in  1  single clock for loader and chain.
- crst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_id  in  ID_WIDTH  target tile ID.
- cmd_len  in  LEN_W  payload length in bits; 0 is legal.
- data_valid  in  1  payload word valid.
- data_ready  out  1  payload word accepted when valid&ready.
- data_word  in  WORD_W  payload, consumed LSB first.
- cfg_in_start  out  1  frame start marker to chain head.
- cfg_bit_in  out  1  serial bit to chain head.
- cfg_out_start  in  1  start marker from chain tail.
- cfg_bit_out  in  1  serial bit from chain tail; unused except in debug.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse on successful echo.
- err  out  2  sticky code: 0 none, 1 underrun, 2 timeout; cleared on next cmd accept.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, word buffer empty, counters 0. Reset mid-frame abandons the frame immediately; the chain sees cfg_in_start=0 and cfg_bit_in=0 from the next cycle.
- Word buffer: 2-entry FIFO. data_ready = not full, independent of state, so prefetch is allowed. Simultaneous push and pop on a full buffer is legal.
- IDLE:
  - cmd_ready = 1 when buffer holds ≥ min(2, ceil(cmd_len/WORD_W)) words. Underruns are only possible later in long frames.
  - On accept: latch id and len, clear err → START.
- START, 1 cycle: cfg_in_start=1, cfg_bit_in=0 → ID.
- ID, ID_WIDTH cycles: cfg_bit_in = id bits MSB first. → PAYLOAD if len>0, else → WAIT_ECHO.
- PAYLOAD, len cycles:
  - cfg_bit_in = current word bit, LSB first.
  - The word is popped on the cycle its last bit is driven, or on the frame's last bit, which discards the remaining bits of a partial word.
  - The next word must be present the cycle after a pop. Otherwise: err=1, drive 0, → IDLE with no done pulse. Buffer contents are kept.
- WAIT_ECHO:
  - cfg_bit_in=0; cycle counter starts at 0.
  - cfg_out_start=1 → done pulse for 1 cycle, → IDLE.
  - Counter reaches TIMEOUT-1 with no echo → err=2, → IDLE.
  - cfg_out_start outside WAIT_ECHO is ignored.
- Latency: cmd accept to last payload bit = 1+ID_WIDTH+len cycles.
- Bit counter is LEN_W wide; len = 2^LEN_W−1 must not wrap.
- Exactly one frame in flight at a time.

Decomposition:
- Shared consts header: ERR_NONE/ERR_UNDERRUN/ERR_TIMEOUT codes, FSM state encodings, ID_WIDTH default.
- One sub-module: cfg_word_fifo, the 2-entry WORD_W FIFO with full/empty/count.
- FSM, serializer and counters live in the top.

Test Plan:
- Basic frame: id=0x07, len=40, words 0xA5A5_0F0F then 0x0000_00C3. Expect:
  - START pulse at cycle t.
  - ID bits 00000111 at t+1..t+8.
  - 40 payload bits LSB first.
  - Tail model echoes 300 cycles later → done pulse, err=0.
- len=0, id=0xFF: start plus 8 ID bits, then WAIT_ECHO; no data_ready pops; echo → done.
- Underrun:
  - Setup: len=96, only 2 words supplied, third withheld.
  - After bit 63, err=1 at the next cycle, busy falls, no done pulse.
  - The next cmd accept clears err.
- Timeout: TIMEOUT=16, no echo → err=2 exactly 16 cycles after WAIT_ECHO entry; done never asserted.
- Back-to-back:
  - Two commands queued, with the data for the second prefetched during the first.
  - The second START occurs 1 cycle after the first done; a stray cfg_out_start during the second PAYLOAD is ignored.
- Reset mid-PAYLOAD: crst high for 1 cycle at bit 10 → next cycle all outputs 0, busy=0, buffer empty, cmd_ready per empty buffer.
